apu_register_interface: RTL

//  CPU-facing write/read front end of the APU register block ($4000-$4017, 5-bit offset).

---
 rtl/apu_pkg.sv | 37 +++
 rtl/apu_frame_reset_timer.sv | 54 +++++
 rtl/apu_register_interface.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/apu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apu_pkg : shared address map, status layout and timer state type     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package apu_pkg;

   localparam logic [4:0] ADDR_P1_0   = 5'h00;
   localparam logic [4:0] ADDR_P1_1   = 5'h01;
   localparam logic [4:0] ADDR_P1_2   = 5'h02;
   localparam logic [4:0] ADDR_P1_3   = 5'h03;
   localparam logic [4:0] ADDR_P2_0   = 5'h04;
   localparam logic [4:0] ADDR_P2_1   = 5'h05;
   localparam logic [4:0] ADDR_P2_2   = 5'h06;
   localparam logic [4:0] ADDR_P2_3   = 5'h07;
   localparam logic [4:0] ADDR_STATUS = 5'h15;
   localparam logic [4:0] ADDR_FRAME  = 5'h17;

   localparam int STATUS_LEN1_BIT = 0;
   localparam int STATUS_LEN2_BIT = 1;
   localparam int STATUS_IRQ_BIT  = 6;

   typedef enum logic [1:0] {
      FR_IDLE  = 2'd0,
      FR_COUNT = 2'd1,
      FR_PULSE = 2'd2
   } fr_state_e;

   function automatic logic [7:0] status_byte(input logic irq, input logic [1:0] len_active);
      status_byte                  = 8'h00;
      status_byte[STATUS_IRQ_BIT]  = irq;
      status_byte[STATUS_LEN1_BIT] = len_active[0];
      status_byte[STATUS_LEN2_BIT] = len_active[1];
   endfunction

endpackage
`default_nettype wire

// File: rtl/apu_frame_reset_timer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apu_frame_reset_timer : delayed one-cycle frame_reset after $4017     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module apu_frame_reset_timer
   import apu_pkg::*;
#(
   parameter int FRAME_RESET_DELAY = 3
) (
   input  logic clk,
   input  logic reset,
   input  logic load,
   output logic frame_reset
);

   // Counting from DELAY-1 puts PULSE exactly DELAY edges after the load edge.
   localparam logic [3:0] LOAD_VAL = 4'(FRAME_RESET_DELAY - 1);

   fr_state_e  state_q, state_d;
   logic [3:0] cnt_q, cnt_d;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= FR_IDLE;
         cnt_q   <= 4'd0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         FR_IDLE:  state_d = FR_IDLE;
         FR_COUNT: begin
            if (cnt_q == 4'd0) state_d = FR_PULSE;
            else               cnt_d   = cnt_q - 4'd1;
         end
         FR_PULSE: state_d = FR_IDLE;
         default:  state_d = FR_IDLE;
      endcase
      if (load) begin
         state_d = FR_COUNT;
         cnt_d   = LOAD_VAL;
      end
   end

   assign frame_reset = (state_q == FR_PULSE);

endmodule
`default_nettype wire

// File: rtl/apu_register_interface.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | apu_register_interface : CPU write/read front end of the APU regs     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module apu_register_interface
   import apu_pkg::*;
#(
   parameter int FRAME_RESET_DELAY = 3,
   parameter bit OPEN_BUS          = 1'b1
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [4:0] cpu_addr,
   input  logic [7:0] cpu_wdata,
   input  logic       cpu_we,
   input  logic       cpu_re,
   output logic [7:0] cpu_rdata,
   output logic       cpu_rvalid,
   output logic [7:0] p1_reg0,
   output logic [7:0] p1_reg1,
   output logic [7:0] p1_reg2,
   output logic [7:0] p1_reg3,
   output logic [7:0] p2_reg0,
   output logic [7:0] p2_reg1,
   output logic [7:0] p2_reg2,
   output logic [7:0] p2_reg3,
   output logic [1:0] p_restart,
   output logic [1:0] p_sweep_reload,
   output logic [1:0] channel_enable,
   output logic [1:0] length_clear,
   input  logic [1:0] length_active,
   input  logic       frame_irq,
   output logic       frame_irq_clear,
   output logic       frame_mode,
   output logic       frame_irq_inhibit,
   output logic       frame_reset
);

   logic [7:0][7:0] img_q, img_d;
   logic [1:0]      restart_q, restart_d, sweep_q, sweep_d;
   logic [1:0]      enable_q, enable_d, len_clr_q, len_clr_d;
   logic            irq_clr_q, irq_clr_d, mode_q, mode_d, inhibit_q, inhibit_d;
   logic [7:0]      rdata_q, rdata_d, open_bus_q, open_bus_d;
   logic            rvalid_q, rvalid_d;
   logic            frame_load;

   always_ff @(posedge clk) begin
      if (reset) begin
         img_q      <= '0;
         restart_q  <= '0;
         sweep_q    <= '0;
         enable_q   <= '0;
         len_clr_q  <= '0;
         irq_clr_q  <= 1'b0;
         mode_q     <= 1'b0;
         inhibit_q  <= 1'b0;
         rdata_q    <= 8'h00;
         rvalid_q   <= 1'b0;
         open_bus_q <= 8'h00;
      end else begin
         img_q      <= img_d;
         restart_q  <= restart_d;
         sweep_q    <= sweep_d;
         enable_q   <= enable_d;
         len_clr_q  <= len_clr_d;
         irq_clr_q  <= irq_clr_d;
         mode_q     <= mode_d;
         inhibit_q  <= inhibit_d;
         rdata_q    <= rdata_d;
         rvalid_q   <= rvalid_d;
         open_bus_q <= open_bus_d;
      end
   end

   always_comb begin
      img_d      = img_q;
      restart_d  = 2'b00;
      sweep_d    = 2'b00;
      enable_d   = enable_q;
      len_clr_d  = 2'b00;
      irq_clr_d  = 1'b0;
      mode_d     = mode_q;
      inhibit_d  = inhibit_q;
      rdata_d    = rdata_q;
      rvalid_d   = cpu_re;
      open_bus_d = open_bus_q;
      frame_load = 1'b0;

      // Read first so a simultaneous write cannot leak into the returned byte.
      if (cpu_re) begin
         if (cpu_addr == ADDR_STATUS) begin
            rdata_d   = status_byte(frame_irq, length_active);
            irq_clr_d = 1'b1;
         end else begin
            rdata_d   = OPEN_BUS ? open_bus_q : 8'h00;
         end
         open_bus_d = rdata_d;
      end

      if (cpu_we) begin
         open_bus_d = cpu_wdata;
         if (cpu_addr < 5'd8) img_d[cpu_addr[2:0]] = cpu_wdata;
         case (cpu_addr)
            ADDR_P1_1:   sweep_d[0]   = 1'b1;
            ADDR_P2_1:   sweep_d[1]   = 1'b1;
            ADDR_P1_3:   restart_d[0] = 1'b1;
            ADDR_P2_3:   restart_d[1] = 1'b1;
            ADDR_STATUS: begin
               enable_d  = cpu_wdata[1:0];
               len_clr_d = ~cpu_wdata[1:0];
            end
            ADDR_FRAME:  begin
               mode_d     = cpu_wdata[7];
               inhibit_d  = cpu_wdata[6];
               frame_load = 1'b1;
            end
            default:     ;
         endcase
      end
   end

   apu_frame_reset_timer #(
      .FRAME_RESET_DELAY(FRAME_RESET_DELAY)
   ) u_frame_reset_timer (
      .clk        (clk),
      .reset      (reset),
      .load       (frame_load),
      .frame_reset(frame_reset)
   );

   assign p1_reg0           = img_q[0];
   assign p1_reg1           = img_q[1];
   assign p1_reg2           = img_q[2];
   assign p1_reg3           = img_q[3];
   assign p2_reg0           = img_q[4];
   assign p2_reg1           = img_q[5];
   assign p2_reg2           = img_q[6];
   assign p2_reg3           = img_q[7];
   assign p_restart         = restart_q;
   assign p_sweep_reload    = sweep_q;
   assign channel_enable    = enable_q;
   assign length_clear      = len_clr_q;
   assign frame_irq_clear   = irq_clr_q;
   assign frame_mode        = mode_q;
   assign frame_irq_inhibit = inhibit_q;
   assign cpu_rdata         = rdata_q;
   assign cpu_rvalid        = rvalid_q;

endmodule
`default_nettype wire
